// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared definitions for the memory arbiter.
//   - DW       : data/address width (32)
//   - state_e  : arbiter FSM state, 2-bit (IDLE, ACCESS, RESP)
//   - owner_e  : port encoding for the current/last owner (OWN_CPU=0, OWN_DMA=1)
package mem_arb_pkg;

  localparam int unsigned DW = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_e;

endpackage

// File: rtl/arb_pick.sv
// arb_pick: combinational owner selection for mem_arbiter.
// Ports:
//   c_req    in   CPU request
//   d_req    in   DMA/loader request
//   last_gnt in   owner of the previous access
//   owner    out  selected owner (meaningful only when a request is present)
// Build option: MEMARB_RR_EN defined -> round-robin on contention
// (the port that did not win last time wins); undefined -> CPU always
// wins on contention and last_gnt is ignored.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic   c_req,
  input  logic   d_req,
  input  owner_e last_gnt,
  output owner_e owner
);

`ifndef MEMARB_RR_EN
  // last_gnt is kept on the interface so both builds share one port list.
  logic unused_last_gnt;
  assign unused_last_gnt = last_gnt;
`endif

  always_comb begin
    owner = OWN_CPU;
    if (c_req && d_req) begin
`ifdef MEMARB_RR_EN
      owner = (last_gnt == OWN_CPU) ? OWN_DMA : OWN_CPU;
`else
      owner = OWN_CPU;
`endif
    end else if (d_req) begin
      owner = OWN_DMA;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (CPU, DMA/loader) arbiter in front of a shared
// single-port synchronous memory.
// Ports:
//   clk, reset (async, active-low)
//   c_req/c_we/c_adr/c_wdata in, c_ack out   CPU port
//   d_req/d_we/d_adr/d_wdata in, d_ack out   DMA/loader port
//   rdata out                                read data, valid with an ack
//   m_en/m_we/m_adr/m_wdata out, m_rdata in  memory port (m_rdata one cycle
//                                            after m_en)
//   busy out                                 high whenever state != IDLE
//   dbg_state_o, dbg_last_gnt_o out          FSM state / last grant
// Build option: MEMARB_RR_EN selects round-robin contention handling
// (see arb_pick); the default build gives the CPU fixed priority.
//
// Handshake: a requester raises req with we/adr/wdata and holds them stable
// until its ack; ack is a single-cycle pulse two cycles after req is
// sampled in IDLE, and req must be low in the cycle after ack. Once an
// access starts it always completes with an ack (a dropped req does not
// abort it); only reset aborts it, silently.
module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [DW-1:0] c_adr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [DW-1:0] d_adr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] rdata,
  output logic          m_en,
  output logic          m_we,
  output logic [DW-1:0] m_adr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic          busy,
  output logic [1:0]    dbg_state_o,
  output logic          dbg_last_gnt_o
);

  state_e state_q;
  owner_e owner_q;
  owner_e last_gnt_q;
  owner_e pick;
  logic   m_en_q;
  logic   m_we_q;
  logic   c_ack_q;
  logic   d_ack_q;
  logic   busy_q;

  arb_pick u_arb_pick (
    .c_req    (c_req),
    .d_req    (d_req),
    .last_gnt (last_gnt_q),
    .owner    (pick)
  );

  // All strobes are registered: they are set on the transition into the
  // state in which they must be visible.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      owner_q    <= OWN_CPU;
      last_gnt_q <= OWN_DMA;
      m_en_q     <= 1'b0;
      m_we_q     <= 1'b0;
      c_ack_q    <= 1'b0;
      d_ack_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (c_req || d_req) begin
            owner_q    <= pick;
            last_gnt_q <= pick;
            state_q    <= ACCESS;
            m_en_q     <= 1'b1;
            m_we_q     <= (pick == OWN_DMA) ? d_we : c_we;
            busy_q     <= 1'b1;
          end
        end
        ACCESS: begin
          state_q <= RESP;
          m_en_q  <= 1'b0;
          m_we_q  <= 1'b0;
          c_ack_q <= (owner_q == OWN_CPU);
          d_ack_q <= (owner_q == OWN_DMA);
        end
        RESP: begin
          state_q <= IDLE;
          c_ack_q <= 1'b0;
          d_ack_q <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          m_en_q  <= 1'b0;
          m_we_q  <= 1'b0;
          c_ack_q <= 1'b0;
          d_ack_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Address/data follow the owner mux in every state; the memory only
  // looks at them while m_en is high.
  assign m_adr          = (owner_q == OWN_DMA) ? d_adr   : c_adr;
  assign m_wdata        = (owner_q == OWN_DMA) ? d_wdata : c_wdata;
  assign m_en           = m_en_q;
  assign m_we           = m_we_q;
  assign c_ack          = c_ack_q;
  assign d_ack          = d_ack_q;
  assign busy           = busy_q;
  assign rdata          = m_rdata;
  assign dbg_state_o    = state_q;
  assign dbg_last_gnt_o = last_gnt_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL have: reset  in  1  asynchronous, active-low (asserted at 0).
REQ-003 SHALL have: c_req  in  1  CPU (multicycle core) access request, level.
REQ-004 SHALL have: c_we  in  1  CPU write enable, qualified by c_req.
REQ-005 SHALL have: c_adr  in  32  CPU byte address; c_wdata  in  32  CPU write data.
REQ-006 SHALL have: c_ack  out  1  CPU access complete, one-cycle pulse.
REQ-007 SHALL have: d_req, d_we, d_adr[31:0], d_wdata[31:0] in, d_ack out; loader/DMA port, same meaning as CPU port.
REQ-008 SHALL have: rdata  out  32  read data, valid only while c_ack or d_ack is high.
REQ-009 SHALL have: m_en  out  1, m_we  out  1, m_adr  out  32, m_wdata  out  32, m_rdata  in  32; shared single-port memory, m_rdata valid the cycle after m_en.
REQ-010 SHALL have: busy  out  1  high in any state other than IDLE.

Function
REQ-011 FSM states SHALL be IDLE, ACCESS, RESP, encoded in a 2-bit enum.
REQ-012 IDLE: if any req high, SHALL select an owner, register it, go to ACCESS; else stay IDLE.
REQ-013 ACCESS: m_en=1, m_we/m_adr/m_wdata SHALL be driven from the owner port; next state RESP.
REQ-014 RESP: owner ack=1 for exactly one cycle, rdata=m_rdata; next state IDLE.
REQ-015 Latency SHALL be 2 cycles from req sampled in IDLE to ack; one access per 3 cycles max.
REQ-016 Requester SHALL hold req/we/adr/wdata stable until ack and drop req in the cycle after ack; arbiter SHALL NOT sample port inputs outside IDLE/ACCESS.
REQ-017 m_en, m_we SHALL be 0 in IDLE and RESP; m_adr/m_wdata don't-care there but driven from owner mux.
REQ-018 c_ack and d_ack SHALL never be high in the same cycle.
REQ-019 A write SHALL be acked in RESP like a read; rdata is don't-care on write ack.
REQ-020 A req dropped before ack (protocol violation) SHALL NOT abort the in-flight access; ack still issued.
REQ-021 last_gnt register (0=CPU, 1=DMA) SHALL update to the owner on every IDLE->ACCESS transition.

Reset
REQ-022 On reset low, asynchronously: state=IDLE, c_ack=d_ack=0, m_en=m_we=0, busy=0, last_gnt=1 (DMA), owner=CPU.
REQ-023 Reset mid-ACCESS/RESP SHALL abort the access with no ack; after release, pending reqs are re-arbitrated from IDLE.

Configuration
REQ-024 Macro MEMARB_RR_EN defined: on simultaneous c_req and d_req the port not equal to last_gnt SHALL win (round-robin).
REQ-025 MEMARB_RR_EN undefined: CPU SHALL always win on contention; last_gnt retained but unused for selection.

Structure
REQ-026 Shared package mem_arb_pkg SHALL hold the state enum, owner encoding (OWN_CPU=0, OWN_DMA=1) and data/address width constant (32).
REQ-027 Selection logic SHALL be a sub-module arb_pick (inputs c_req, d_req, last_gnt; output owner); everything else in mem_arbiter.

Verification
REQ-028 Reset held 15 ns then released, no reqs -> state IDLE, busy=0, all acks 0, m_en=0 for 10 cycles.
REQ-029 c_req=1, c_we=0, c_adr=0x20, memory[0x20]=0xE3A00005 -> m_en=1 with m_adr=0x20 one cycle later, c_ack=1 and rdata=0xE3A00005 two cycles after sampling.
REQ-030 d_req=1, d_we=1, d_adr=0x40, d_wdata=0x12345678 -> m_we=1 in ACCESS, d_ack pulse in RESP, later CPU read of 0x40 returns 0x12345678.
REQ-031 c_req and d_req held continuously, MEMARB_RR_EN defined -> grants alternate CPU, DMA, CPU, DMA (first grant CPU); undefined -> CPU granted every access, d_ack never asserts.
REQ-032 reset driven low during ACCESS of a CPU read -> no c_ack, m_en=0 immediately; after release with c_req still high, access reissued and c_ack follows 2 cycles after sampling.
